mem_sweep_ctrl: RTL and testbench
=================================

// Module: mem_sweep_ctrl
// PURPOSE
//  Sequencer for the single-clock simple-dual-port block RAM (memory, WID_MEM x DEPTH_MEM).
//  On command it sweeps every address: fills the RAM with a known pattern, reads it back and
//  compares it, or does both. Reports mismatch count and first failing address.
//  Sits between test/reinit control logic and the RAM ports; the only driver of them while busy.
// PARAMETERS
//  WID_MEM    4     RAM data width, bits (>=1)
//  DEPTH_MEM  4096  RAM depth, words (>=1); addresses 0..DEPTH_MEM-1
//  CNT_W      16    width of err_count (>=1)
// PORTS
//  clk             in   1        clock, rising edge
//  reset           in   1        synchronous, active-high reset
//  start           in   1        begin a sweep; sampled only in IDLE
//  mode            in   2        00=FILL, 01=VERIFY, 10=FILL then VERIFY, 11=reserved (start ignored)
//  pat_sel         in   1        0=constant pattern, 1=address-keyed pattern
//  pat_value       in   WID_MEM  pattern seed; captured with mode/pat_sel on accepted start
//  busy            out  1        high from the cycle after an accepted start until done
//  done            out  1        one-cycle pulse at sweep end
//  pass            out  1        err_count==0 at end of last sweep; held until next accepted start
//  err_count       out  CNT_W    mismatches in current/last verify; saturates at all-ones
//  first_err_addr  out  32       address of first mismatch; 0 if none
//  mem_raddr       out  32       RAM read address
//  mem_waddr       out  32       RAM write address
//  mem_we          out  1        RAM write enable
//  mem_din         out  WID_MEM  RAM write data
//  mem_dout        in   WID_MEM  RAM read data; valid 1 cycle after mem_raddr (registered read)
// BEHAVIOUR
//  - Reset: state=IDLE; busy=0, done=0, pass=0, err_count=0, first_err_addr=0, mem_we=0,
//    mem_raddr=0, mem_waddr=0, mem_din=0. Reset mid-sweep aborts immediately; no done pulse.
//  - expected(a) = pat_sel ? pat_value ^ a[WID_MEM-1:0] : pat_value (a zero-extended if WID_MEM>32).
//  - States: IDLE -> FILL | VERIFY; FILL -> VERIFY (mode 10) | DONE; VERIFY -> DRAIN -> DONE -> IDLE.
//  - IDLE: start with mode!=11 is accepted; captures mode/pat_sel/pat_value, clears err_count,
//    first_err_addr, pass; addr counter=0. start while busy or mode 11: ignored, no effect.
//  - FILL: one write per cycle; mem_we=1, mem_waddr=addr, mem_din=expected(addr); addr 0..DEPTH_MEM-1.
//    Exactly DEPTH_MEM cycles. Counter wraps to 0 on leaving. mem_we=0 in every other state.
//  - VERIFY: mem_raddr=addr, one read issued per cycle for DEPTH_MEM cycles; a delayed valid +
//    address pipeline stage compares mem_dout to expected(addr_d) the following cycle.
//  - DRAIN: one cycle; compares the final read (address DEPTH_MEM-1). No new read issued.
//  - Mismatch: err_count += 1 unless all-ones; first_err_addr loaded only on first mismatch.
//  - DONE: done=1 for one cycle, busy=0 in that cycle, pass=(err_count==0) registered; -> IDLE.
//    FILL-only sweep: pass=1.
//  - Latency start->done: FILL DEPTH_MEM+2; VERIFY DEPTH_MEM+3; FILL+VERIFY 2*DEPTH_MEM+3 cycles.
//  - DEPTH_MEM=1: FILL 1 cycle, VERIFY 1 cycle + DRAIN; no special casing.
//  - Counter width = max(1,$clog2(DEPTH_MEM)); last-address compare, not overflow, ends a phase.
//  - Read/write same-address hazard never arises: write and read phases are disjoint.
// CONFIGURATION
//  MEM_SWEEP_STOP_ON_ERR_EN defined: first mismatch in VERIFY stops issuing reads; the next
//    cycle goes to DONE (pass=0, err_count=1, first_err_addr=failing address). The one read
//    still in flight is discarded.
//  Not defined: VERIFY always covers all DEPTH_MEM addresses and counts every mismatch.
// TESTING
//  1 Reset mid-FILL (addr=100) -> next cycle busy=0, mem_we=0, done never pulses, err_count=0.
//  2 DEPTH_MEM=16, mode=10, pat_sel=1, pat_value=4'hA -> RAM[5]=4'hF; done at cycle 35; pass=1.
//  3 After fill, backdoor-corrupt RAM[3] and RAM[9]; mode=01 -> err_count=2, first_err_addr=3, pass=0.
//  4 start pulsed during busy, and start with mode=11 in IDLE -> ignored; captured pattern unchanged.
//  5 CNT_W=1, 3 corrupted words -> err_count=1 (saturated), pass=0.
//  6 MEM_SWEEP_STOP_ON_ERR_EN, corrupt RAM[7] and RAM[12] -> done 2 cycles after addr-7 read
//    data returns; err_count=1, first_err_addr=7.

Source files
------------

// File: rtl/mem_sweep_if.sv
// mem_sweep_if: RAM-side bundle between mem_sweep_ctrl and a registered-read simple dual-port RAM.
interface mem_sweep_if #(parameter int WID_MEM = 4);
  logic [31:0] mem_raddr;
  logic [31:0] mem_waddr;
  logic mem_we;
  logic [WID_MEM-1:0] mem_din;
  logic [WID_MEM-1:0] mem_dout;
  modport master(output mem_raddr, mem_waddr, mem_we, mem_din, input mem_dout);
  modport slave(input mem_raddr, mem_waddr, mem_we, mem_din, output mem_dout);
endinterface

// File: rtl/mem_sweep_ctrl.sv
// mem_sweep_ctrl: fill/verify address sweeper for a registered-read RAM, with error count and first failing address.
// Optional: define MEM_SWEEP_STOP_ON_ERR_EN to end VERIFY at the first mismatch.
module mem_sweep_ctrl #(
  parameter int WID_MEM = 4,
  parameter int DEPTH_MEM = 4096,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  input logic start,
  input logic [1:0] mode,
  input logic pat_sel,
  input logic [WID_MEM-1:0] pat_value,
  output logic busy,
  output logic done,
  output logic pass,
  output logic [CNT_W-1:0] err_count,
  output logic [31:0] first_err_addr,
  mem_sweep_if.master mem
);
  localparam int AW = DEPTH_MEM > 1 ? $clog2(DEPTH_MEM) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH_MEM - 1);
  typedef enum logic [2:0] {IDLE, FILL, VERIFY, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [AW-1:0] addr, addr_n, addr_d;
  logic chain_q, sel_q, vld_d, accept, last, miss, stop;
  logic [WID_MEM-1:0] pat_q;
  function automatic logic [WID_MEM-1:0] expected(input logic sel, input logic [WID_MEM-1:0] pat,
                                                  input logic [AW-1:0] a);
    return sel ? pat ^ WID_MEM'(a) : pat;
  endfunction
  assign accept = state == IDLE && start && mode != 2'b11;
  assign last = addr == LAST;
  assign miss = vld_d && mem.mem_dout != expected(sel_q, pat_q, addr_d);
`ifdef MEM_SWEEP_STOP_ON_ERR_EN
  assign stop = miss && state == VERIFY;
`else
  assign stop = 1'b0;
`endif
  always_comb begin
    state_n = state;
    addr_n = addr;
    case (state)
      IDLE: begin
        state_n = accept ? (mode[0] ? VERIFY : FILL) : IDLE;
        addr_n = accept ? '0 : addr;
      end
      FILL: begin
        state_n = last ? (chain_q ? VERIFY : DONE) : FILL;
        addr_n = last ? '0 : addr + 1'b1;
      end
      VERIFY: begin
        state_n = stop ? DONE : last ? DRAIN : VERIFY;
        addr_n = (last || stop) ? '0 : addr + 1'b1;
      end
      DRAIN: state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    busy = state != IDLE;
    mem.mem_we = state == FILL;
    mem.mem_waddr = state == FILL ? 32'(addr) : '0;
    mem.mem_din = state == FILL ? expected(sel_q, pat_q, addr) : '0;
    mem.mem_raddr = state == VERIFY ? 32'(addr) : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      addr <= '0;
      addr_d <= '0;
      vld_d <= 1'b0;
      chain_q <= 1'b0;
      sel_q <= 1'b0;
      pat_q <= '0;
      done <= 1'b0;
      pass <= 1'b0;
      err_count <= '0;
      first_err_addr <= '0;
    end else begin
      state <= state_n;
      addr <= addr_n;
      addr_d <= addr;
      // a read issued in the stopping cycle is dropped
      vld_d <= state == VERIFY && !stop;
      done <= state == DONE;
      if (accept) begin
        chain_q <= mode[1];
        sel_q <= pat_sel;
        pat_q <= pat_value;
        pass <= 1'b0;
        err_count <= '0;
        first_err_addr <= '0;
      end else if (miss) begin
        if (err_count == '0) first_err_addr <= 32'(addr_d);
        if (~&err_count) err_count <= err_count + 1'b1;
      end
      if (state == DONE) pass <= err_count == '0;
    end
  end
endmodule

// File: tb/tb_mem_sweep_ctrl.sv
// tb_mem_sweep_ctrl: table-driven directed bench; twin DUTs (CNT_W=16 and CNT_W=1) share stimulus.
module tb_mem_sweep_ctrl;
  localparam int W = 4;
  localparam int D = 16;
`ifdef MEM_SWEEP_STOP_ON_ERR_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, pat_sel = 1'b0, cpulse = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [W-1:0] pat_value = '0;
  logic [D-1:0] cmask = '0;
  logic busy, done, pass, busy1, done1, pass1;
  logic [15:0] err_count;
  logic [0:0] err1;
  logic [31:0] first_err_addr, first1;
  logic [W-1:0] ram0 [D];
  logic [W-1:0] ram1 [D];
  int total = 0, bad = 0;
  int lat, nbad, seen;
  logic bok;
  typedef struct {
    logic [1:0] mode;
    logic ps;
    logic [W-1:0] pv;
    logic [D-1:0] mask;
    int lat;
    int err;
    int first;
    logic pass;
    logic ram_chk;
  } vec_t;
  vec_t vt [10];
  mem_sweep_if #(.WID_MEM(W)) m0 ();
  mem_sweep_if #(.WID_MEM(W)) m1 ();
  mem_sweep_ctrl #(.WID_MEM(W), .DEPTH_MEM(D), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .pat_sel(pat_sel), .pat_value(pat_value),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .first_err_addr(first_err_addr), .mem(m0));
  mem_sweep_ctrl #(.WID_MEM(W), .DEPTH_MEM(D), .CNT_W(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .pat_sel(pat_sel), .pat_value(pat_value),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .first_err_addr(first1), .mem(m1));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    for (int i = 0; i < D; i++)
      if (cpulse && cmask[i]) begin
        ram0[i] <= ram0[i] ^ 4'h8;
        ram1[i] <= ram1[i] ^ 4'h8;
      end
    if (m0.mem_we) ram0[m0.mem_waddr[3:0]] <= m0.mem_din;
    if (m1.mem_we) ram1[m1.mem_waddr[3:0]] <= m1.mem_din;
    m0.mem_dout <= ram0[m0.mem_raddr[3:0]];
    m1.mem_dout <= ram1[m1.mem_raddr[3:0]];
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  initial begin
    vt[0] = '{2'b00, 1'b1, 4'hA, 16'h0000, 18, 0, 0, 1'b1, 1'b1};
    vt[1] = '{2'b01, 1'b1, 4'hA, 16'h0000, 19, 0, 0, 1'b1, 1'b0};
    vt[2] = '{2'b01, 1'b1, 4'hA, 16'h0208, STOP ? 7 : 19, STOP ? 1 : 2, 3, 1'b0, 1'b0};
    vt[3] = '{2'b10, 1'b0, 4'h5, 16'h0000, 35, 0, 0, 1'b1, 1'b1};
    vt[4] = '{2'b10, 1'b1, 4'hA, 16'h0000, 35, 0, 0, 1'b1, 1'b1};
    vt[5] = '{2'b01, 1'b1, 4'hA, 16'h4006, STOP ? 5 : 19, STOP ? 1 : 3, 1, 1'b0, 1'b0};
    vt[6] = '{2'b00, 1'b1, 4'hA, 16'h0000, 18, 0, 0, 1'b1, 1'b1};
    vt[7] = '{2'b01, 1'b0, 4'h0, 16'h0000, STOP ? 4 : 19, STOP ? 1 : 15, 0, 1'b0, 1'b0};
    vt[8] = '{2'b01, 1'b1, 4'h3, 16'h0000, STOP ? 4 : 19, STOP ? 1 : 16, 0, 1'b0, 1'b0};
    vt[9] = '{2'b01, 1'b1, 4'hA, 16'h8000, 19, 1, 15, 1'b0, 1'b0};
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_first", first_err_addr, 0);
    chk("rst_we", m0.mem_we, 0);
    chk("rst_raddr", m0.mem_raddr, 0);
    chk("rst_waddr", m0.mem_waddr, 0);
    chk("rst_din", m0.mem_din, 0);
    reset = 1'b0;
    for (int v = 0; v < 10; v++) begin
      @(negedge clk);
      cmask = vt[v].mask;
      cpulse = 1'b1;
      @(negedge clk);
      cpulse = 1'b0;
      mode = vt[v].mode;
      pat_sel = vt[v].ps;
      pat_value = vt[v].pv;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      mode = 2'b11;
      pat_sel = ~vt[v].ps;
      pat_value = ~vt[v].pv;
      lat = 1;
      bok = 1'b1;
      while (!done && lat < 200) begin
        if (!busy || !busy1 || done1) bok = 1'b0;
        start = lat == 2;
        @(negedge clk);
        lat++;
      end
      start = 1'b0;
      chk($sformatf("v%0d_latency", v), lat, vt[v].lat);
      chk($sformatf("v%0d_busy_run", v), bok, 1);
      chk($sformatf("v%0d_busy_done", v), busy, 0);
      chk($sformatf("v%0d_err", v), err_count, vt[v].err);
      chk($sformatf("v%0d_first", v), first_err_addr, vt[v].first);
      chk($sformatf("v%0d_pass", v), pass, vt[v].pass);
      chk($sformatf("v%0d_done1", v), done1, 1);
      chk($sformatf("v%0d_err_sat", v), err1, vt[v].err != 0);
      chk($sformatf("v%0d_pass1", v), pass1, vt[v].pass);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", v), done, 0);
      if (vt[v].ram_chk) begin
        nbad = 0;
        for (int i = 0; i < D; i++) begin
          if (ram0[i] !== (vt[v].ps ? vt[v].pv ^ 4'(i) : vt[v].pv)) nbad++;
          if (ram1[i] !== (vt[v].ps ? vt[v].pv ^ 4'(i) : vt[v].pv)) nbad++;
        end
        chk($sformatf("v%0d_ram_words", v), nbad, 0);
      end
    end
    chk("ram5_keyed", ram0[5], 4'hF);
    @(negedge clk);
    mode = 2'b11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    repeat (4) begin
      if (busy || done || m0.mem_we) seen++;
      @(negedge clk);
    end
    chk("mode11_ignored", seen, 0);
    chk("mode11_err_kept", err_count, 1);
    chk("mode11_first_kept", first_err_addr, 15);
    mode = 2'b00;
    pat_sel = 1'b1;
    pat_value = 4'hA;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    while (m0.mem_waddr != 8 && seen < 40) begin
      @(negedge clk);
      seen++;
    end
    chk("fill_reached_8", m0.mem_waddr, 8);
    chk("fill_we", m0.mem_we, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_we", m0.mem_we, 0);
    chk("abort_err", err_count, 0);
    seen = 0;
    repeat (25) begin
      if (done || done1 || busy) seen++;
      @(negedge clk);
    end
    chk("abort_no_done", seen, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
